cp0_intc: RTL and testbench
===========================

# cp0_intc

Coprocessor-0 interrupt/exception unit on the CPU side of the device interrupt lines. It receives level-sensitive interrupt requests from bus peripherals such as the timer/counter, and masks them through the status register. It raises a single interrupt request to the pipeline and records the return PC and cause on entry. It exposes SR/Cause/EPC/PRId to `mfc0`/`mtc0` and clears the exception level on `eret`.

## Interface
- `PRID`, 32'h0000_5A01, constant value returned for register 15.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `we`  in  1  `mtc0` write strobe.
- `addr`  in  5  CP0 register number for read and write: 12 SR, 13 Cause, 14 EPC, 15 PRId.
- `din`  in  32  `mtc0` write data.
- `dout`  out  32  `mfc0` read data, combinational from `addr`.
- `pc`  in  32  PC of the instruction being interrupted or faulting; bits [1:0] are ignored.
- `hwint`  in  6  device interrupt lines, level-high; bit 0 = timer.
- `exc`  in  1  synchronous exception request from the pipeline.
- `exccode`  in  5  exception code accompanying `exc`.
- `eret`  in  1  return-from-exception strobe.
- `int_req`  out  1  take-exception request to the pipeline, combinational.
- `epc`  out  32  current EPC, used by `eret` for redirect.

## Operation
- SR fields: IM = SR[15:10], EXL = SR[1], IE = SR[0]. All other SR bits read 0 and writes to them are dropped.
- Cause fields:
  - IP = Cause[15:10], loaded from `hwint` every cycle. IP is read-only to `mtc0`.
  - ExcCode = Cause[6:2].
  - All other Cause bits read 0.
- EPC is 32 bits wide, bits [1:0] are always 0, and `epc` equals EPC.
- Pending interrupt is `hw_pend = |(hwint & IM) & IE & ~EXL`.
- `int_req = hw_pend | (exc & ~EXL)`.
- Entry cycle (`int_req` = 1), at clk edge:
  - EXL <= 1.
  - EPC <= {pc[31:2], 2'b00}.
  - ExcCode <= 0 if `hw_pend`, else `exccode`. A hardware interrupt wins over a simultaneous exception.
  - `we` in the same cycle is ignored entirely.
- `eret` with `int_req` = 0 sets EXL <= 0. If EXL = 1, `int_req` is already 0, so `eret` is never blocked by `hwint`.
- `mtc0` (`we`=1, `int_req`=0):
  - addr 12 writes IM, EXL, IE.
  - addr 14 writes EPC with {din[31:2], 2'b00}.
  - addr 13 writes nothing, and neither does addr 15 or any other address.
- `eret` and `mtc0` to SR in the same cycle: the written EXL value applies, then `eret` forces EXL = 0. The net result is IM/IE from `din` and EXL = 0.
- `exc` while EXL = 1 is dropped: no EPC update, no `int_req`.
- Read mux: 12 gives SR, 13 gives Cause, 14 gives EPC, 15 gives `PRID`, any other address gives 0.

## Timing
- Reset (synchronous, at clk edge): SR = 0, Cause = 0, EPC = 0. As a result `int_req` = 0 and `epc` = 0 from the first cycle after reset.
- `int_req` is combinational: a `hwint` bit rising with IM/IE set gives `int_req` = 1 in the same cycle.
- EXL, EPC and ExcCode update at the clk edge ending the entry cycle. `int_req` drops the next cycle even if `hwint` stays high.
- IP shows `hwint` one cycle late, because it is registered.
- `mtc0` effects are visible on `dout` and `int_req` the cycle after the write.
- Reset mid-service (EXL = 1) returns all registers to 0. `hwint` is then masked, because IE = 0.

## Test plan
- **Reset values:** assert `rst` 1 cycle, then read addr 12/13/14/15 -> 0, 0, 0, 32'h0000_5A01; `int_req` = 0.
- **Masking:** write SR = 32'h0000_0401 (IM0 = 1, IE = 1), then raise `hwint` = 6'b000001 with `pc` = 32'h0000_3010.
  - Same cycle: `int_req` = 1.
  - Next cycle: EXL = 1, `epc` = 32'h0000_3010, `int_req` = 0 while `hwint` stays high.
- **IE/IM gating:**
  - SR = 32'h0000_0400 (IE = 0) with `hwint` = 1 -> `int_req` stays 0.
  - SR = 32'h0000_0801 with `hwint` = 1 -> `int_req` = 0.
  - Read Cause -> 32'h0000_0400.
- **`eret` with level held:** in service, hold `hwint` = 1 and pulse `eret` -> EXL = 0 next cycle, then `int_req` = 1 again. Deassert `hwint` -> `int_req` = 0.
- **Priority:** `exc` = 1 with `exccode` = 5'd10 plus `hwint` = 1 (enabled) -> ExcCode = 0. Repeat with `hwint` = 0 -> Cause = 32'h0000_0028.
- **Write collisions:**
  - `mtc0` EPC = 32'h0000_4003 -> reads 32'h0000_4000.
  - `mtc0` EPC during an entry cycle -> EPC takes `pc`, not `din`.
  - `mtc0` to addr 13 -> Cause unchanged.

Source files
------------

// File: rtl/cp0_intc.sv
// cp0_intc: coprocessor-0 interrupt/exception unit.
//
// Masks level-sensitive device interrupts through SR, raises a single
// take-exception request to the pipeline, records EPC and ExcCode on entry,
// and exposes SR/Cause/EPC/PRId to mfc0/mtc0. eret clears the exception level.
//
// Ports:
//   clk      clock
//   rst      synchronous active-high reset
//   we       mtc0 write strobe
//   addr     CP0 register number (12 SR, 13 Cause, 14 EPC, 15 PRId)
//   din      mtc0 write data
//   dout     mfc0 read data, combinational from addr
//   pc       PC of the interrupted/faulting instruction (bits [1:0] ignored)
//   hwint    device interrupt lines, level-high, bit 0 = timer
//   exc      synchronous exception request
//   exccode  exception code accompanying exc
//   eret     return-from-exception strobe
//   int_req  take-exception request, combinational
//   epc      current EPC
module cp0_intc #(
  parameter logic [31:0] PRID = 32'h0000_5A01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic [31:0] pc,
  input  logic [5:0]  hwint,
  input  logic        exc,
  input  logic [4:0]  exccode,
  input  logic        eret,
  output logic        int_req,
  output logic [31:0] epc
);

  localparam logic [4:0] AddrSr    = 5'd12;
  localparam logic [4:0] AddrCause = 5'd13;
  localparam logic [4:0] AddrEpc   = 5'd14;
  localparam logic [4:0] AddrPrid  = 5'd15;

  // Only the architecturally defined fields are stored; everything else reads 0.
  logic [5:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  logic [5:0]  ip_q;
  logic [4:0]  exccode_q;
  logic [31:2] epc_q;

  logic        hw_pend;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic [31:0] epc_val;

  assign hw_pend = (|(hwint & im_q)) & ie_q & ~exl_q;
  assign int_req = hw_pend | (exc & ~exl_q);

  assign sr_val    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_val = {16'b0, ip_q, 3'b0, exccode_q, 2'b00};
  assign epc_val   = {epc_q, 2'b00};
  assign epc       = epc_val;

  always_comb begin
    dout = 32'b0;
    case (addr)
      AddrSr:    dout = sr_val;
      AddrCause: dout = cause_val;
      AddrEpc:   dout = epc_val;
      AddrPrid:  dout = PRID;
      default:   dout = 32'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im_q      <= 6'b0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      ip_q      <= 6'b0;
      exccode_q <= 5'b0;
      epc_q     <= 30'b0;
    end else begin
      ip_q <= hwint;
      if (int_req) begin
        // Entry cycle: any concurrent mtc0 is dropped; hardware interrupt
        // takes priority over a simultaneous synchronous exception.
        exl_q     <= 1'b1;
        epc_q     <= pc[31:2];
        exccode_q <= hw_pend ? 5'd0 : exccode;
      end else begin
        if (we && addr == AddrSr) begin
          im_q  <= din[15:10];
          exl_q <= din[1];
          ie_q  <= din[0];
        end
        if (we && addr == AddrEpc) begin
          epc_q <= din[31:2];
        end
        // Placed after the SR write so eret overrides a written EXL.
        if (eret) begin
          exl_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_intc.sv
module tb_cp0_intc;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [31:0] pc;
  logic [5:0]  hwint;
  logic        exc;
  logic [4:0]  exccode;
  logic        eret;
  logic        int_req;
  logic [31:0] epc;

  int n_checks = 0;
  int n_errors = 0;

  cp0_intc dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .pc      (pc),
    .hwint   (hwint),
    .exc     (exc),
    .exccode (exccode),
    .eret    (eret),
    .int_req (int_req),
    .epc     (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we   = 1'b1;
    addr = a;
    din  = d;
    tick();
    we   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; addr = 5'd0; din = 32'b0; pc = 32'b0;
    hwint = 6'b0; exc = 1'b0; exccode = 5'd0; eret = 1'b0;
    tick();
    rst = 1'b0;

    // Reset values
    rd_check("rst_sr", 5'd12, 32'h0);
    rd_check("rst_cause", 5'd13, 32'h0);
    rd_check("rst_epc", 5'd14, 32'h0);
    rd_check("rst_prid", 5'd15, 32'h0000_5A01);
    check("rst_int_req", {31'b0, int_req}, 32'h0);
    check("rst_epc_out", epc, 32'h0);

    // Masking / entry
    mtc0(5'd12, 32'h0000_0401);
    hwint = 6'b000001; pc = 32'h0000_3010;
    #1 check("entry_req", {31'b0, int_req}, 32'h1);
    tick();
    check("entry_req_drop", {31'b0, int_req}, 32'h0);
    check("entry_epc", epc, 32'h0000_3010);
    rd_check("entry_sr", 5'd12, 32'h0000_0403);
    rd_check("entry_cause", 5'd13, 32'h0000_0400);

    // eret with level held
    eret = 1'b1;
    #1 check("eret_same_cycle", {31'b0, int_req}, 32'h0);
    tick();
    eret = 1'b0;
    #1 check("eret_rereq", {31'b0, int_req}, 32'h1);
    rd_check("eret_sr", 5'd12, 32'h0000_0401);
    hwint = 6'b0;
    #1 check("hwint_low", {31'b0, int_req}, 32'h0);
    tick();

    // IE/IM gating
    mtc0(5'd12, 32'h0000_0400);
    hwint = 6'b000001;
    #1 check("ie_gate", {31'b0, int_req}, 32'h0);
    tick();
    mtc0(5'd12, 32'h0000_0801);
    #1 check("im_gate", {31'b0, int_req}, 32'h0);
    rd_check("gate_cause", 5'd13, 32'h0000_0400);

    // Priority: hardware interrupt beats exception
    mtc0(5'd12, 32'h0000_0401);
    exc = 1'b1; exccode = 5'd10; pc = 32'h0000_5004;
    #1 check("prio_req", {31'b0, int_req}, 32'h1);
    tick();
    exc = 1'b0;
    rd_check("prio_cause", 5'd13, 32'h0000_0400);
    check("prio_epc", epc, 32'h0000_5004);
    hwint = 6'b0; eret = 1'b1;
    tick();
    eret = 1'b0;
    exc = 1'b1; exccode = 5'd10; pc = 32'h0000_6008;
    #1 check("exc_req", {31'b0, int_req}, 32'h1);
    tick();
    exc = 1'b0;
    rd_check("exc_cause", 5'd13, 32'h0000_0028);
    check("exc_epc", epc, 32'h0000_6008);

    // Exception while EXL=1 is dropped
    exc = 1'b1; exccode = 5'd4; pc = 32'h0000_7000;
    #1 check("exl_exc_req", {31'b0, int_req}, 32'h0);
    tick();
    exc = 1'b0;
    check("exl_exc_epc", epc, 32'h0000_6008);
    rd_check("exl_exc_cause", 5'd13, 32'h0000_0028);

    // Write collisions
    mtc0(5'd14, 32'h0000_4003);
    rd_check("epc_wr", 5'd14, 32'h0000_4000);
    check("epc_wr_out", epc, 32'h0000_4000);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd_check("cause_ro", 5'd13, 32'h0000_0028);
    mtc0(5'd15, 32'h1234_5678);
    rd_check("prid_ro", 5'd15, 32'h0000_5A01);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    hwint = 6'b000001; pc = 32'h0000_8000;
    we = 1'b1; addr = 5'd14; din = 32'h0000_1234;
    #1 check("coll_req", {31'b0, int_req}, 32'h1);
    tick();
    we = 1'b0;
    check("coll_epc", epc, 32'h0000_8000);
    rd_check("coll_sr", 5'd12, 32'h0000_0403);

    // eret together with mtc0 SR: IM/IE from din, EXL forced 0
    we = 1'b1; addr = 5'd12; din = 32'h0000_0C03; eret = 1'b1;
    tick();
    we = 1'b0; eret = 1'b0;
    rd_check("eret_mtc0_sr", 5'd12, 32'h0000_0C01);
    check("eret_mtc0_req", {31'b0, int_req}, 32'h1);
    rd_check("unmapped_3", 5'd3, 32'h0);
    rd_check("unmapped_16", 5'd16, 32'h0);

    // Reset mid-service
    tick();
    rd_check("pre_rst_sr", 5'd12, 32'h0000_0C03);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_check("mid_rst_sr", 5'd12, 32'h0);
    rd_check("mid_rst_cause", 5'd13, 32'h0);
    rd_check("mid_rst_epc", 5'd14, 32'h0);
    check("mid_rst_req", {31'b0, int_req}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
